// File: rtl/shared_register_arbiter_pkg.sv
// Shared definitions for the shared-register arbiter.
// Holds FSM state encodings and the index-width helper.
package shared_register_arbiter_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_ACK  = 2'd2
   } state_t;

   // Width of a requester index; a single requester still needs 1 bit.
   function automatic int idx_width(input int m);
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/register_load_arst.sv
// N-bit loadable register, async active-low reset to zero.
// Ports: i_clk, i_rst_n, i_load, i_d[N], o_q[N].
module register_load_arst #(
   parameter int N = 4
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_load,
   input  logic [N-1:0] i_d,
   output logic [N-1:0] o_q
);

   logic [N-1:0] r_q;
   logic [N-1:0] w_d_next;

   always_comb begin
      w_d_next = i_load ? i_d : r_q;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_q <= '0;
      end else begin
         r_q <= w_d_next;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/shared_register_arbiter.sv
// Round-robin arbiter sharing one loadable register among M requesters.
// Ports: clk, reset_n, req[M], data[M*N] in; ack[M], Q[N], owner[W], busy out.
module shared_register_arbiter
   import shared_register_arbiter_pkg::*;
#(
   parameter  int N = 4,
   parameter  int M = 4,
   localparam int W = idx_width(M)
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic [M-1:0]   req,
   input  logic [M*N-1:0] data,
   output logic [M-1:0]   ack,
   output logic [N-1:0]   Q,
   output logic [W-1:0]   owner,
   output logic           busy
);

   state_t       r_state;
   logic [W-1:0] r_owner;
   logic [W-1:0] r_last;
   logic [M-1:0] r_ack;

   logic         w_load;
   logic [N-1:0] w_data;
   logic [W-1:0] w_winner;

   // Scan from the requester after the last served one, wrapping.
   always_comb begin : arb
      int           idx;
      logic [W-1:0] sel;
      logic         found;
      w_winner = '0;
      found    = 1'b0;
      idx      = 0;
      sel      = '0;
      for (int k = 1; k <= M; k++) begin
         idx = int'(r_last) + k;
         if (idx >= M) idx = idx - M;
         sel = W'(idx);
         if (!found && req[sel]) begin
            found    = 1'b1;
            w_winner = sel;
         end
      end
   end

   always_comb begin
      w_data = '0;
      for (int i = 0; i < M; i++) begin
         if (r_owner == W'(i)) w_data = data[i*N +: N];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_owner <= '0;
         r_last  <= W'(M-1);
         r_ack   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (|req) begin
                  r_owner <= w_winner;
                  r_state <= S_LOAD;
               end
            end
            // Load is committed here regardless of req[owner].
            S_LOAD: begin
               r_ack   <= {{(M-1){1'b0}}, 1'b1} << r_owner;
               r_state <= S_ACK;
            end
            S_ACK: begin
               if (!req[r_owner]) begin
                  r_ack   <= '0;
                  r_last  <= r_owner;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_ack   <= '0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign w_load = (r_state == S_LOAD);
   assign busy   = (r_state != S_IDLE);
   assign ack    = r_ack;
   assign owner  = r_owner;

   register_load_arst #(
      .N(N)
   ) u_reg (
      .i_clk  (clk),
      .i_rst_n(reset_n),
      .i_load (w_load),
      .i_d    (w_data),
      .o_q    (Q)
   );

endmodule
